// File: rtl/imem_loader.sv
// Boot-time loader: assembles a byte stream into LE 32-bit words and writes them into instruction RAM.
// Latency: 4 length bytes, then 4 bytes + 1 write cycle per word (5 cycles/word at full rate).
// Backpressure: rx_ready only in LEN/DATA; deasserted during the WRITE cycle and in IDLE/DONE/ERROR.
//
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   start                - begin a load (honoured in IDLE, DONE, ERROR only)
//   rx_data/valid/ready  - byte stream, valid/ready handshake
//   is_write/im_addr/im_inst - instruction RAM write port
//   core_hold            - hold the core (low only in DONE)
//   done/error           - outcome of the last load
//   words_loaded         - words written in the current or last load
module imem_loader #(
  parameter int             w         = 32,
  parameter int             MAX_WORDS = 2048,
  parameter logic [w-1:0]   BASE_ADDR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic         is_write,
  output logic [w-1:0] im_addr,
  output logic [w-1:0] im_inst,
  output logic         core_hold,
  output logic         done,
  output logic         error,
  output logic [w-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [w-1:0] MAX_LEN = w'(MAX_WORDS);

  state_t       state_q, state_d;
  logic [1:0]   byte_cnt_q, byte_cnt_d;
  logic [w-1:0] len_q, len_d;
  logic [w-1:0] asm_q, asm_d;
  logic [w-1:0] words_q, words_d;
  logic         accept;

  // Outputs decode registered state only; nothing combinational from rx_valid.
  assign rx_ready     = (state_q == S_LEN) || (state_q == S_DATA);
  assign is_write     = (state_q == S_WRITE);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign core_hold    = (state_q != S_DONE);
  assign im_addr      = BASE_ADDR + (words_q << 2);
  assign im_inst      = asm_q;
  assign words_loaded = words_q;

  assign accept = rx_valid && rx_ready;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    asm_d      = asm_q;
    words_d    = words_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN;
          byte_cnt_d = 2'd0;
          words_d    = '0;
        end
      end

      S_LEN: begin
        if (accept) begin
          // Shifting in from the top leaves the first byte in [7:0] after four bytes.
          len_d      = {rx_data, len_q[w-1:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if ((len_d == '0) || (len_d > MAX_LEN)) begin
              state_d = S_ERROR;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          asm_d      = {rx_data, asm_q[w-1:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        words_d = words_q + 1'b1;
        if (words_d == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      len_q      <= '0;
      asm_q      <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
      words_q    <= words_d;
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the pipelined core's instruction RAM. It accepts a byte stream over a valid/ready interface, assembles little-endian 32-bit instruction words and writes them one at a time into the instruction RAM's write port (`is_write`/`im_addr`/`im_inst`). While a load is in progress, and from reset until the first successful load, it holds the core so fetch never observes a partially written program.

## Interface
Parameters:
- `w`, 32: data/address width; must match the instruction RAM.
- `MAX_WORDS`, 2048: largest accepted program length, in words.
- `BASE_ADDR`, 0: byte address of the first word written; word-aligned.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- `rx_data` in 8: incoming stream byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte this cycle.
- `is_write` out 1: instruction RAM write strobe.
- `im_addr` out w: instruction RAM write byte address.
- `im_inst` out w: instruction RAM write data.
- `core_hold` out 1: core must stall or stay in reset while high.
- `done` out 1: last load completed successfully.
- `error` out 1: last load was rejected.
- `words_loaded` out w: words written in the current or last load.

## Operation
- States: IDLE, LEN, DATA, WRITE, DONE, ERROR.
- A byte is accepted only when `rx_valid && rx_ready`. `rx_ready` = 1 only in LEN and DATA.
- IDLE: waits for `start`; `start` moves to LEN, clears `words_loaded`, `done`, `error` and the byte counter.
- LEN: accepts 4 bytes, the first byte into bits [7:0], forming length N.
  - After the 4th byte, if N == 0 or N > MAX_WORDS, go to ERROR; otherwise go to DATA.
- DATA: accepts 4 bytes per word, little-endian, into a w-bit shift/assembly register. The 4th byte moves to WRITE.
- WRITE: lasts exactly one cycle.
  - `is_write` = 1, `im_inst` = assembled word, `im_addr` = BASE_ADDR + 4*`words_loaded` (mod 2^w).
  - `words_loaded` increments at the end of the cycle.
  - If the incremented count == N, go to DONE; else return to DATA.
- DONE: `done` = 1, `core_hold` = 0. Stays here until `start`, which begins a new load (back to LEN).
- ERROR: `error` = 1, `core_hold` = 1, no writes. Stays here until `start` or `rst`.
- `core_hold` = 1 in every state except DONE.
- `start` is ignored in LEN, DATA and WRITE.
- Bytes arriving while `rx_ready` = 0 are not consumed. The source must hold them, per the valid/ready rule.
- `is_write` is never asserted outside WRITE. `im_addr` and `im_inst` may hold stale values when `is_write` = 0.

## Timing
- Reset values:
  - state IDLE
  - `rx_ready` 0, `is_write` 0
  - `im_addr` = BASE_ADDR, `im_inst` 0
  - `core_hold` 1, `done` 0, `error` 0
  - `words_loaded` 0, byte counter 0
- All outputs are registered or decoded directly from registered state; there is no combinational path from `rx_valid` to any output.
- `start` at edge t: LEN is active in cycle t+1, so `rx_ready` = 1 from t+1.
- Per word: 4 accepted bytes, then 1 WRITE cycle with `rx_ready` = 0. Full-rate stream gives 5 cycles per word.
- Program of N words with a continuous stream: `done` rises 4 + 5N cycles after the first LEN cycle.
- `core_hold` falls in the same cycle `done` rises. `core_hold` rises in the cycle after a new `start`.
- Byte gaps (`rx_valid` = 0) stall the FSM in LEN/DATA with no timeout. Partial words are retained.
- `rst` asserted mid-load aborts immediately: no further writes, outputs take reset values asynchronously, and RAM contents already written are left as is.
- `start` coincident with the final WRITE cycle is ignored; the load ends in DONE.

## Test plan
- Reset, then stream len = 2 and bytes 13 00 00 00, 93 00 10 00 -> writes 0x00000013 @0x0 and 0x00100093 @0x4. `done` = 1 and `core_hold` = 0 at cycle 4+5·2 after LEN entry; `words_loaded` = 2.
- Len = 0 -> ERROR, `error` = 1, `core_hold` = 1, no `is_write`. Len = MAX_WORDS+1 -> same result.
- Len = MAX_WORDS with full-rate stream -> exactly MAX_WORDS writes. Last `im_addr` = BASE_ADDR + 4·(MAX_WORDS−1); `done` = 1.
- Random `rx_valid` gaps within words, plus `start` pulses during DATA -> identical written words and addresses; starts are ignored.
- Assert `rst` after 1.5 words of a 4-word load -> one write only, all outputs return to reset values. A subsequent `start` reloads correctly from `words_loaded` = 0.
- After DONE, `start` with a new 1-word image -> `core_hold` rises next cycle, the word is written at BASE_ADDR, then `done` = 1 again.
